// File: rtl/uart_tx_sm_if.sv
// rtl/uart_tx_sm_if.sv - Valid/Ready byte handshake between the host/FIFO side and the UART transmitter
interface uart_tx_sm_if;
  logic [7:0] Din;
  logic       Valid;
  logic       Ready;

  modport master (output Din, output Valid, input Ready);
  modport slave  (input Din, input Valid, output Ready);
endinterface

// File: rtl/uart_tx_sm.sv
// rtl/uart_tx_sm.sv - UART transmit serializer paced by the 16x bit-rate clock enable
// Optional parity: define UART_TX_PARITY_EN to add ParEn/ParOdd and the PAR state.
module uart_tx_sm (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        CE_16x,
  input  logic        Len,
  input  logic        NumStop,
`ifdef UART_TX_PARITY_EN
  input  logic        ParEn,
  input  logic        ParOdd,
`endif
  uart_tx_sm_if.slave host,
  output logic        TxD,
  output logic        Busy
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PAR,
`endif
    STOP1,
    STOP2
  } state_t;

  state_t     state;
  logic [3:0] bit_cnt;
  logic [2:0] dat_cnt;
  logic [7:0] sr;
  logic       len_q;
  logic       stop_q;
`ifdef UART_TX_PARITY_EN
  logic       par_en_q;
  logic       par_odd_q;
  logic       par_acc;
`endif

  logic       bit_end;
  logic       last_data;

  // A bit slot closes on the 16th enable pulse; last data bit depends on the latched length
  assign bit_end   = CE_16x & (bit_cnt == 4'd15);
  assign last_data = (dat_cnt == (len_q ? 3'd6 : 3'd7));

  // Ready must drop in the same cycle Rst is asserted, so it cannot wait for the register
  assign host.Ready = (state == IDLE) & ~Rst;

  // Frame sequencer; TxD and Busy are registered from the next state so the line moves on the deciding edge
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= IDLE;
      TxD       <= 1'b1;
      Busy      <= 1'b0;
      bit_cnt   <= 4'd0;
      dat_cnt   <= 3'd0;
      sr        <= 8'd0;
      len_q     <= 1'b0;
      stop_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en_q  <= 1'b0;
      par_odd_q <= 1'b0;
      par_acc   <= 1'b0;
`endif
    end else begin
      // The 4-bit counter wraps 15 -> 0 by itself, which is exactly the bit boundary
      if ((state != IDLE) && CE_16x) begin
        bit_cnt <= bit_cnt + 4'd1;
      end

      case (state)
        IDLE: begin
          if (host.Valid) begin
            sr        <= host.Din;
            len_q     <= Len;
            stop_q    <= NumStop;
`ifdef UART_TX_PARITY_EN
            par_en_q  <= ParEn;
            par_odd_q <= ParOdd;
            par_acc   <= 1'b0;
`endif
            bit_cnt   <= 4'd0;
            dat_cnt   <= 3'd0;
            state     <= START;
            TxD       <= 1'b0;
            Busy      <= 1'b1;
          end
        end

        START: begin
          if (bit_end) begin
            state <= DATA;
            TxD   <= sr[0];
          end
        end

        DATA: begin
          if (bit_end) begin
            sr      <= {1'b0, sr[7:1]};
            dat_cnt <= dat_cnt + 3'd1;
`ifdef UART_TX_PARITY_EN
            par_acc <= par_acc ^ sr[0];
`endif
            if (last_data) begin
`ifdef UART_TX_PARITY_EN
              if (par_en_q) begin
                state <= PAR;
                TxD   <= par_acc ^ sr[0] ^ par_odd_q;
              end else begin
                state <= STOP1;
                TxD   <= 1'b1;
              end
`else
              state <= STOP1;
              TxD   <= 1'b1;
`endif
            end else begin
              TxD <= sr[1];
            end
          end
        end

`ifdef UART_TX_PARITY_EN
        PAR: begin
          if (bit_end) begin
            state <= STOP1;
            TxD   <= 1'b1;
          end
        end
`endif

        STOP1: begin
          if (bit_end) begin
            TxD <= 1'b1;
            if (stop_q) begin
              state <= STOP2;
            end else begin
              state <= IDLE;
              Busy  <= 1'b0;
            end
          end
        end

        STOP2: begin
          if (bit_end) begin
            state <= IDLE;
            TxD   <= 1'b1;
            Busy  <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          TxD   <= 1'b1;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_sm.sv
// tb/tb_uart_tx_sm.sv - directed scoreboard bench for uart_tx_sm
module tb_uart_tx_sm;

  logic Clk;
  logic Rst;
  logic CE_16x;
  logic Len;
  logic NumStop;
  logic ParEn;
  logic ParOdd;
  logic TxD;
  logic Busy;

  uart_tx_sm_if bus ();

  uart_tx_sm dut (
    .Clk     (Clk),
    .Rst     (Rst),
    .CE_16x  (CE_16x),
    .Len     (Len),
    .NumStop (NumStop),
`ifdef UART_TX_PARITY_EN
    .ParEn   (ParEn),
    .ParOdd  (ParOdd),
`endif
    .host    (bus),
    .TxD     (TxD),
    .Busy    (Busy)
  );

  typedef struct {
    logic [7:0] din;
    logic       len;
    logic       nstop;
    logic       pen;
    logic       podd;
  } frame_t;

  frame_t      frm_q[$];
  logic        seg_q[$];
  int          n_checks;
  int          n_pass;
  int          acc_cnt;
  logic        active;
  logic        cur_lvl;
  int          seg_rem;
  int          ce_mode;
  int unsigned ce_cnt;
  logic        mon_en;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic chkn(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Expected line levels of one frame, each lasting 16 enable pulses after the accept edge
  task automatic load_frame(input frame_t f);
    logic par;
    int   nb;
    nb  = f.len ? 7 : 8;
    par = f.podd;
    seg_q.delete();
    for (int i = 0; i < nb; i++) begin
      seg_q.push_back(f.din[i]);
      par = par ^ f.din[i];
    end
    if (f.pen) seg_q.push_back(par);
    seg_q.push_back(1'b1);
    if (f.nstop) seg_q.push_back(1'b1);
    cur_lvl = 1'b0;
    seg_rem = 16;
    active  = 1'b1;
  endtask

  task automatic push_frame(input logic [7:0] d, input logic l, input logic s,
                            input logic pe, input logic po);
    frame_t f;
    f.din   = d;
    f.len   = l;
    f.nstop = s;
`ifdef UART_TX_PARITY_EN
    f.pen   = pe;
`else
    f.pen   = 1'b0;
`endif
    f.podd  = pe & po;
    frm_q.push_back(f);
  endtask

  task automatic xfer(input logic [7:0] d, input logic l, input logic s,
                      input logic pe, input logic po, input logic hold, output int n);
    int base;
    bus.Din = d;
    Len     = l;
    NumStop = s;
    ParEn   = pe;
    ParOdd  = po;
    push_frame(d, l, s, pe, po);
    base      = acc_cnt;
    bus.Valid = 1'b1;
    n = 0;
    while (acc_cnt == base && n < 3000) begin
      @(negedge Clk);
      n++;
    end
    chkn("accept_seen", acc_cnt, base + 1);
    if (!hold) bus.Valid = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!bus.Ready && n < 3000) begin
      @(negedge Clk);
      n++;
    end
  endtask

  // Free-running system clock
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Baud enable source: continuous, every 4th clock, or stalled
  initial begin
    ce_cnt = 0;
    CE_16x = 1'b1;
    forever begin
      @(negedge Clk);
      ce_cnt = ce_cnt + 1;
      case (ce_mode)
        0:       CE_16x = 1'b1;
        1:       CE_16x = (ce_cnt % 4 == 0);
        default: CE_16x = 1'b0;
      endcase
    end
  end

  // Reference model: advances expected level on enables, pops a frame on each handshake
  always @(posedge Clk) begin
    logic was_active;
    was_active = active;
    if (Rst) begin
      active = 1'b0;
      seg_q.delete();
    end else begin
      if (active && CE_16x) begin
        seg_rem--;
        if (seg_rem == 0) begin
          if (seg_q.size() > 0) begin
            cur_lvl = seg_q.pop_front();
            seg_rem = 16;
          end else begin
            active = 1'b0;
          end
        end
      end
      if (bus.Valid && bus.Ready) begin
        acc_cnt++;
        chk1("accept_when_idle", was_active, 1'b0);
        chk1("accept_expected", frm_q.size() > 0, 1'b1);
        if (frm_q.size() > 0) load_frame(frm_q.pop_front());
      end
    end
  end

  // Line and Busy compared against the model every cycle, away from the active edge
  always @(negedge Clk) begin
    if (mon_en) begin
      chk1("txd", TxD, active ? cur_lvl : 1'b1);
      chk1("busy", Busy, active);
    end
  end

  // Directed sequence
  initial begin
    int n;
    int b0;
    n_checks  = 0;
    n_pass    = 0;
    acc_cnt   = 0;
    active    = 1'b0;
    cur_lvl   = 1'b1;
    seg_rem   = 0;
    mon_en    = 1'b0;
    ce_mode   = 0;
    Rst       = 1'b1;
    bus.Valid = 1'b1;
    bus.Din   = 8'h5A;
    Len       = 1'b0;
    NumStop   = 1'b0;
    ParEn     = 1'b0;
    ParOdd    = 1'b0;

    // Reset with Valid high: no accept, line idle
    repeat (3) @(negedge Clk);
    chk1("rst_ready", bus.Ready, 1'b0);
    chk1("rst_txd", TxD, 1'b1);
    chk1("rst_busy", Busy, 1'b0);
    mon_en    = 1'b1;
    bus.Valid = 1'b0;
    Rst       = 1'b0;
    #1;
    chk1("ready_after_rst", bus.Ready, 1'b1);

    // T1: 8N1 0x55, format inputs scrambled mid-frame
    xfer(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, n);
    bus.Din = 8'h00;
    Len     = 1'b1;
    NumStop = 1'b1;
    wait_ready(n);
    chkn("t1_frame_cycles", n, 160);

    // T2: 7 data bits, 2 stop bits, 0xFF
    xfer(8'hFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, n);
    wait_ready(n);
    chkn("t2_frame_cycles", n, 160);

`ifdef UART_TX_PARITY_EN
    // T3: parity over 0x07, even then odd
    xfer(8'h07, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, n);
    wait_ready(n);
    chkn("t3_even_cycles", n, 176);
    xfer(8'h07, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, n);
    wait_ready(n);
    chkn("t3_odd_cycles", n, 176);
`endif

    // Enable stalled for 50 clocks inside data bit 1 of 0xC3
    xfer(8'hC3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, n);
    repeat (40) @(negedge Clk);
    #2 ce_mode = 2;
    repeat (50) @(negedge Clk);
    chk1("stall_hold", TxD, 1'b1);
    #2 ce_mode = 0;
    wait_ready(n);
    chkn("stall_remaining", n, 120);

    // T4: enable every 4th clock, Valid held with 0xA5 across two frames
    ce_mode = 1;
    n = 0;
    do begin
      @(negedge Clk);
      #1;
      n++;
    end while (CE_16x !== 1'b1 && n < 10);
    b0 = acc_cnt;
    xfer(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, n);
    push_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
    n = 0;
    while (Busy && n < 3000) begin
      @(negedge Clk);
      n++;
    end
    chkn("t4_busy_cycles", n, 640);
    repeat (600) @(negedge Clk);
    bus.Valid = 1'b0;
    chkn("t4_one_accept_per_frame", acc_cnt, b0 + 2);
    wait_ready(n);
    ce_mode = 0;
    repeat (2) @(negedge Clk);

    // T5: reset during data bit 3, then a clean 0x3C frame
    xfer(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, n);
    repeat (70) @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    chk1("t5_abort_txd", TxD, 1'b1);
    chk1("t5_abort_busy", Busy, 1'b0);
    chk1("t5_ready_in_rst", bus.Ready, 1'b0);
    Rst = 1'b0;
    #1;
    chk1("t5_ready_after", bus.Ready, 1'b1);
    xfer(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, n);
    wait_ready(n);
    chkn("t5_frame_cycles", n, 160);

    // T6: back-to-back 0x12, 0x34 with Valid held
    xfer(8'h12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, n);
    xfer(8'h34, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, n);
    chkn("t6_second_accept", n, 161);
    wait_ready(n);
    chkn("t6_frame_cycles", n, 160);

    repeat (4) @(negedge Clk);
    mon_en = 1'b0;
    chkn("scoreboard_empty", frm_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
